imem_fetch_arbiter: RTL
=======================

Name: imem_fetch_arbiter

Overview:
- Sequences and shares the single-port, byte-wide, synchronous-read instruction memory between two requesters: the fetch stage and the program loader.
- A fetch request is serviced as four byte reads, assembled big-endian into one 32-bit instruction word.
- A loader write is serviced as one byte write per handshake.
- Sits between the IF stage PC logic and the instruction RAM macro.

Parameters:
- WIDTH, 32, byte-address width of fetch_addr and ld_addr.
- MEM_DEPTH, 1024, memory size in bytes; must be a power of two.
- AW, $clog2(MEM_DEPTH), memory address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request; held with fetch_addr until accepted.
- fetch_addr  in  WIDTH  byte address of the instruction.
- fetch_ready  out  1  request accepted in any cycle where fetch_req && fetch_ready.
- fetch_flush  in  1  abort the in-flight fetch (branch redirect).
- fetch_valid  out  1  one-cycle pulse; fetch_instr is valid in that cycle.
- fetch_instr  out  32  assembled instruction.
- ld_req  in  1  loader byte-write request.
- ld_addr  in  WIDTH  loader byte address.
- ld_data  in  8  loader write data.
- ld_ack  out  1  write performed this cycle.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  read data, valid one cycle after the read cycle (mem_en && !mem_we).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, beat counter=0, byte shift register=0.
  - fetch_valid=0, fetch_instr=0, ld_ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-fetch discards all progress; no valid is produced.
- FSM states: IDLE, READ, DRAIN, RESP.
- IDLE:
  - If ld_req: loader write this cycle, combinationally. mem_en=1, mem_we=1, mem_addr=ld_addr[AW-1:0], mem_wdata=ld_data, ld_ack=1, fetch_ready=0. Stay in IDLE.
  - Else fetch_ready=1. If fetch_req: latch base=fetch_addr[AW-1:0], go to READ with beat=0.
  - The loader has fixed priority over fetch in IDLE.
- READ:
  - One read per cycle: mem_en=1, mem_we=0, mem_addr=(base+beat) mod MEM_DEPTH.
  - The byte returned from the previous beat is shifted in.
  - After beat 3 is issued, go to DRAIN.
- DRAIN: capture the beat-3 byte, go to RESP.
- RESP:
  - fetch_valid = !fetch_flush.
  - fetch_instr = {byte0, byte1, byte2, byte3}; byte0 is the byte at the lowest address and lands in [31:24].
  - Go to IDLE.
- Latency: accept cycle T → reads issued in T+1..T+4 → fetch_valid in T+6. Next acceptance is possible at T+7.
- fetch_instr is registered and holds its last value between pulses.
- While state != IDLE: fetch_ready=0 and ld_ack=0. A pending ld_req waits and is never dropped; the loader never interrupts a fetch.
- fetch_flush in READ or DRAIN: next state is IDLE, no fetch_valid. Outstanding read data is ignored.
- fetch_flush in RESP: fetch_valid is suppressed that cycle.
- fetch_flush in IDLE: no effect; a same-cycle request is still accepted.
- Address wrap: base + beat wraps modulo MEM_DEPTH. Address bits above AW are ignored.

Optional Feature:
- Macro: IMEM_ALIGN_CHECK_EN.
- Defined:
  - Extra output fetch_err (1 bit).
  - On acceptance, if fetch_addr[1:0] != 0 or fetch_addr >= MEM_DEPTH-3: skip READ and DRAIN, no memory access.
  - Enter RESP the next cycle (valid at T+2) with fetch_instr = 32'h00000013 (NOP) and fetch_err=1 in the fetch_valid cycle.
  - fetch_err resets to 0.
- Undefined: no fetch_err port; every address is fetched with modulo wrap.

Decomposition:
- Shared package riscv_if_pkg:
  - FSM state enum.
  - NOP_INSTR = 32'h00000013.
  - FETCH_BEATS = 4.
- No sub-module. The byte shift register and beat counter stay inline; the block is a single FSM.

Test Plan:
- Fetch preload: mem[0x10..0x13] = 00 A0 00 93. Request fetch_addr=0x10 accepted at T → fetch_valid only at T+6, fetch_instr=32'h00A00093, mem_addr sequence 0x10,0x11,0x12,0x13 in T+1..T+4.
- Loader priority: ld_req and fetch_req both high in IDLE → ld_ack=1 and a write that cycle with fetch_ready=0. ld_req raised during READ → ld_ack=0 until IDLE, then written. Fetch of the written word returns the new bytes.
- Flush: fetch_flush pulse at T+3 → no fetch_valid, state IDLE at T+4, fetch_ready=1. Flush exactly in the RESP cycle → fetch_valid=0.
- Wrap, with MEM_DEPTH=1024 and macro undefined: fetch_addr=0x3FE → reads 0x3FE,0x3FF,0x000,0x001.
- Reset: rst_n low at T+2 of a fetch → all outputs 0 immediately. After release, fetch_addr=0x0 works with 6-cycle latency.
- IMEM_ALIGN_CHECK_EN defined: fetch_addr=0x12 → fetch_valid at T+2, fetch_instr=32'h00000013, fetch_err=1, mem_en never asserted.

Source files
------------

// File: rtl/riscv_if_pkg.sv
// riscv_if_pkg: shared types and constants for the instruction fetch path
package riscv_if_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int FETCH_BEATS = 4;
endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// imem_fetch_arbiter_if: fetch, loader and RAM-side signals of the instruction memory arbiter
// fetch_err exists only when IMEM_ALIGN_CHECK_EN is defined.
interface imem_fetch_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int AW = 10
) ();
   logic fetch_req;
   logic [WIDTH-1:0] fetch_addr;
   logic fetch_ready;
   logic fetch_flush;
   logic fetch_valid;
   logic [31:0] fetch_instr;
`ifdef IMEM_ALIGN_CHECK_EN
   logic fetch_err;
`endif
   logic ld_req;
   logic [WIDTH-1:0] ld_addr;
   logic [7:0] ld_data;
   logic ld_ack;
   logic mem_en;
   logic mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   modport master (
      output fetch_req, fetch_addr, fetch_flush, ld_req, ld_addr, ld_data, mem_rdata,
`ifdef IMEM_ALIGN_CHECK_EN
      input fetch_err,
`endif
      input fetch_ready, fetch_valid, fetch_instr, ld_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input fetch_req, fetch_addr, fetch_flush, ld_req, ld_addr, ld_data, mem_rdata,
`ifdef IMEM_ALIGN_CHECK_EN
      output fetch_err,
`endif
      output fetch_ready, fetch_valid, fetch_instr, ld_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares the byte-wide instruction RAM between 4-beat big-endian fetches and loader writes
// Optional IMEM_ALIGN_CHECK_EN: misaligned or out-of-range fetches return NOP with fetch_err, no RAM access.
module imem_fetch_arbiter
   import riscv_if_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   localparam int AW = $clog2(MEM_DEPTH)
) (
   input logic clk,
   input logic rst_n,
   imem_fetch_arbiter_if.slave bus
);
   state_t state;
   logic [1:0] beat;
   logic [AW-1:0] base;
   logic [23:0] shreg;
   logic [31:0] instr_q;
   logic [31:0] assembled;
   logic ld_go;
   logic accept;
   logic unused_addr_hi;
   assign unused_addr_hi = ^{bus.fetch_addr[WIDTH-1:AW], bus.ld_addr[WIDTH-1:AW]};
   // Loader wins only while idle; a pending ld_req simply waits out a fetch.
   assign ld_go = rst_n && state == IDLE && bus.ld_req;
   assign bus.fetch_ready = rst_n && state == IDLE && !bus.ld_req;
   assign accept = bus.fetch_ready && bus.fetch_req;
   assign bus.ld_ack = ld_go;
   assign bus.mem_en = ld_go || state == READ;
   assign bus.mem_we = ld_go;
   assign bus.mem_addr = ld_go ? bus.ld_addr[AW-1:0] : state == READ ? base + AW'(beat) : '0;
   assign bus.mem_wdata = ld_go ? bus.ld_data : 8'h00;
   assign bus.fetch_valid = state == RESP && !bus.fetch_flush;
   assign bus.fetch_instr = instr_q;
`ifdef IMEM_ALIGN_CHECK_EN
   logic err_q;
   logic bad;
   assign bad = bus.fetch_addr[1:0] != 2'b00 || bus.fetch_addr >= WIDTH'(MEM_DEPTH - 3);
   assign bus.fetch_err = bus.fetch_valid && err_q;
   assign assembled = err_q ? NOP_INSTR : {shreg, bus.mem_rdata};
`else
   assign assembled = {shreg, bus.mem_rdata};
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         beat <= '0;
         base <= '0;
         shreg <= '0;
         instr_q <= '0;
`ifdef IMEM_ALIGN_CHECK_EN
         err_q <= 1'b0;
`endif
      end else
         case (state)
            IDLE: if (accept) begin
               base <= bus.fetch_addr[AW-1:0];
               beat <= '0;
`ifdef IMEM_ALIGN_CHECK_EN
               err_q <= bad;
               state <= bad ? DRAIN : READ;
`else
               state <= READ;
`endif
            end
            // Byte from the previous beat arrives one cycle late, so beat 0 shifts nothing.
            READ: if (bus.fetch_flush) state <= IDLE;
            else begin
               if (beat != 2'd0) shreg <= {shreg[15:0], bus.mem_rdata};
               beat <= beat + 2'd1;
               if (beat == 2'(FETCH_BEATS - 1)) state <= DRAIN;
            end
            DRAIN: begin
               state <= bus.fetch_flush ? IDLE : RESP;
               if (!bus.fetch_flush) instr_q <= assembled;
            end
            default: state <= IDLE;
         endcase
endmodule
